// File: rtl/vga_wb_pkg.sv
// vga_wb_pkg: Wishbone CTI/BTE encodings, slave FSM states and burst address stepping
package vga_wb_pkg;
  localparam int AW = 30;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4 = 2'b01;
  localparam logic [1:0] BTE_WRAP8 = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  typedef enum logic [2:0] {IDLE, WAIT, ACK, PAUSE, ERR} state_t;
  function automatic logic [AW-1:0] next_burst_adr(input logic [AW-1:0] adr, input logic [1:0] bte);
    logic [AW-1:0] inc;
    inc = adr + AW'(1);
    return bte == BTE_WRAP4  ? {adr[AW-1:2], inc[1:0]} :
           bte == BTE_WRAP8  ? {adr[AW-1:3], inc[2:0]} :
           bte == BTE_WRAP16 ? {adr[AW-1:4], inc[3:0]} : inc;
  endfunction
endpackage

// File: rtl/vga_wb_vmem_ram.sv
// vga_wb_vmem_ram: single-port sync-read RAM, 32-bit words, 4 byte enables (clk_i, we, sel, adr, wdat -> rdat)
module vga_wb_vmem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [3:0]            sel,
  input  logic [DEPTH_LOG2-1:0] adr,
  input  logic [31:0]           wdat,
  output logic [31:0]           rdat
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) if (we && sel[i]) mem[adr][8*i +: 8] <= wdat[8*i +: 8];
    rdat <= mem[adr];
  end
endmodule

// File: rtl/vga_wb_vmem_slave.sv
// vga_wb_vmem_slave: Wishbone video memory slave with wait states, CTI/BTE bursts, ack/err and busy_o
module vga_wb_vmem_slave
  import vga_wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          busy_o
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [AW-1:0] adr_q, adr_d, adr_nx;
  logic we_q, we_d;
  logic [2:0] cti_q, cti_d;
  logic [1:0] bte_q, bte_d;
  logic req, burst, ram_we;
  logic [DEPTH_LOG2-1:0] ram_adr;
  logic [DW-1:0] ram_dat;
  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};
  assign req = wb_cyc_i & wb_stb_i;
  assign burst = cti_q == CTI_INCR;
  assign adr_nx = next_burst_adr(adr_q, bte_q);
  assign ram_we = state == ACK && we_q && req;
  assign ram_adr = ram_we ? adr_q[DEPTH_LOG2-1:0] : adr_d[DEPTH_LOG2-1:0];
  assign wb_ack_o = state == ACK;
  assign wb_err_o = state == ERR;
  assign busy_o = state != IDLE;
  assign wb_dat_o = wb_ack_o ? ram_dat : '0;
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= IDLE;
      cnt <= '0;
      adr_q <= '0;
      we_q <= 1'b0;
      cti_q <= CTI_CLASSIC;
      bte_q <= BTE_LINEAR;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      adr_q <= adr_d;
      we_q <= we_d;
      cti_q <= cti_d;
      bte_q <= bte_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    adr_d = adr_q;
    we_d = we_q;
    cti_d = cti_q;
    bte_d = bte_q;
    case (state)
      IDLE: if (req) begin
        adr_d = wb_adr_i[31:2];
        we_d = wb_we_i;
        cti_d = wb_cti_i;
        bte_d = wb_bte_i;
        cnt_d = WS;
        state_d = |wb_adr_i[31:DEPTH_LOG2+2] ? ERR : WS == 4'd0 ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        state_d = !wb_cyc_i ? IDLE : cnt == 4'd1 ? ACK : WAIT;
      end
      ACK: if (req && burst && wb_cti_i != CTI_EOB) begin
        adr_d = adr_nx;
        state_d = |adr_nx[AW-1:DEPTH_LOG2] ? ERR : ACK;
      end else begin
        state_d = wb_cyc_i && burst && !wb_stb_i ? PAUSE : IDLE;
      end
      PAUSE: state_d = !wb_cyc_i ? IDLE : wb_stb_i ? ACK : PAUSE;
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  vga_wb_vmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i(clk_i),
    .we(ram_we),
    .sel(wb_sel_i),
    .adr(ram_adr),
    .wdat(wb_dat_i),
    .rdat(ram_dat)
  );
endmodule

// File: tb/tb_vga_wb_vmem_slave.sv
// tb_vga_wb_vmem_slave: directed checks of classic, burst, pause, abort, error and reset behaviour
module tb_vga_wb_vmem_slave;
  import vga_wb_pkg::*;
  logic clk_i = 1'b0;
  logic nrst_i = 1'b0;
  logic wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0] wb_sel_i;
  logic [2:0] wb_cti_i;
  logic [1:0] wb_bte_i;
  logic wb_ack_o, wb_err_o, busy_o;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk_i = ~clk_i;
  vga_wb_vmem_slave #(.DW(32), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
    .clk_i(clk_i),
    .nrst_i(nrst_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i),
    .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic bus_idle;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_cti_i = CTI_CLASSIC;
    wb_bte_i = BTE_LINEAR;
  endtask
  task automatic wait_ack(output int w);
    w = 0;
    while (!wb_ack_o && w < 20) begin
      tick;
      w++;
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic ak, output logic er, output int lat, output logic after);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = w;
    wb_adr_i = a;
    wb_dat_i = d;
    wb_sel_i = s;
    wb_cti_i = CTI_CLASSIC;
    wb_bte_i = BTE_LINEAR;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!wb_ack_o && !wb_err_o && lat < 20);
    rd = wb_dat_o;
    ak = wb_ack_o;
    er = wb_err_o;
    tick;
    after = wb_ack_o | wb_err_o;
    bus_idle;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    logic ak, unused_er, unused_after;
    int unused_lat;
    xfer(1'b1, a, d, s, unused_rd, ak, unused_er, unused_lat, unused_after);
    chk("wr ack", 32'(ak), 1);
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic unused_ak, unused_er, unused_after;
    int unused_lat;
    xfer(1'b0, a, '0, '0, rd, unused_ak, unused_er, unused_lat, unused_after);
    chk(tag, rd, exp);
  endtask
  task automatic burst_rd(input string tag, input logic [31:0] a, input logic [1:0] bte, input int n, input int pause_at,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_d [4];
    int w;
    exp_d = '{e0, e1, e2, e3};
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = 1'b0;
    wb_adr_i = a;
    wb_bte_i = bte;
    wb_cti_i = n == 1 ? CTI_EOB : CTI_INCR;
    wait_ack(w);
    chk({tag, " first ack latency"}, 32'(w), 3);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s beat %0d ack", tag, k), 32'(wb_ack_o), 1);
      chk($sformatf("%s beat %0d dat", tag, k), wb_dat_o, exp_d[k]);
      wb_cti_i = k == n - 1 ? CTI_EOB : CTI_INCR;
      tick;
      if (k + 1 == pause_at) begin
        wb_stb_i = 1'b0;
        tick;
        chk({tag, " pause ack"}, 32'(wb_ack_o), 0);
        chk({tag, " pause busy"}, 32'(busy_o), 1);
        tick;
        wb_stb_i = 1'b1;
        chk({tag, " resume ack"}, 32'(wb_ack_o), 0);
        tick;
      end
    end
    chk({tag, " ack after eob"}, 32'(wb_ack_o), 0);
    bus_idle;
    tick;
  endtask
  initial begin
    logic [31:0] rd;
    logic ak, er, after;
    int lat, w;
    bus_idle;
    repeat (3) tick;
    chk("rst ack", 32'(wb_ack_o), 0);
    chk("rst err", 32'(wb_err_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst dat", wb_dat_o, 0);
    nrst_i = 1'b1;
    tick;
    wr(32'h40, 32'hCAFE0001, 4'hF);
    xfer(1'b0, 32'h40, '0, '0, rd, ak, er, lat, after);
    chk("classic rd latency", 32'(lat), 3);
    chk("classic rd ack", 32'(ak), 1);
    chk("classic rd dat", rd, 32'hCAFE0001);
    chk("classic rd ack cycle 4", 32'(after), 0);
    wr(32'h14, 32'h11223344, 4'hF);
    wr(32'h14, 32'hAABBCCDD, 4'b0101);
    rd_chk("byte lane write", 32'h14, 32'h11BB33DD);
    for (int i = 0; i < 8; i++) wr(32'h100 + 32'(4 * i), 32'(i), 4'hF);
    burst_rd("linear", 32'h100, BTE_LINEAR, 4, 0, 0, 1, 2, 3);
    burst_rd("wrap4", 32'h108, BTE_WRAP4, 4, 0, 2, 3, 0, 1);
    burst_rd("wrap8", 32'h118, BTE_WRAP8, 4, 0, 6, 7, 0, 1);
    burst_rd("pause", 32'h100, BTE_LINEAR, 3, 1, 0, 1, 2, 0);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'h40;
    tick;
    chk("abort busy in wait", 32'(busy_o), 1);
    bus_idle;
    tick;
    chk("abort ack", 32'(wb_ack_o), 0);
    chk("abort busy", 32'(busy_o), 0);
    tick;
    chk("abort no late ack", 32'(wb_ack_o), 0);
    wr(32'h0, 32'h5A5A5A5A, 4'hF);
    xfer(1'b1, 32'h0000_1000, 32'hDEADBEEF, 4'hF, rd, ak, er, lat, after);
    chk("err latency", 32'(lat), 1);
    chk("err err", 32'(er), 1);
    chk("err ack", 32'(ak), 0);
    chk("err one cycle", 32'(after), 0);
    rd_chk("err mem unchanged", 32'h0, 32'h5A5A5A5A);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'hFFC;
    wb_cti_i = CTI_INCR;
    wait_ack(w);
    chk("top burst first ack", 32'(w), 3);
    tick;
    bus_idle;
    chk("top burst err", 32'(wb_err_o), 1);
    chk("top burst ack", 32'(wb_ack_o), 0);
    tick;
    chk("top burst err drop", 32'(wb_err_o), 0);
    chk("top burst idle", 32'(busy_o), 0);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'h100;
    wb_cti_i = CTI_INCR;
    wait_ack(w);
    tick;
    chk("midburst ack before rst", 32'(wb_ack_o), 1);
    nrst_i = 1'b0;
    #1;
    chk("midburst rst ack", 32'(wb_ack_o), 0);
    chk("midburst rst busy", 32'(busy_o), 0);
    chk("midburst rst dat", wb_dat_o, 0);
    bus_idle;
    tick;
    nrst_i = 1'b1;
    tick;
    chk("after rst idle", 32'(busy_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
